pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline latches (PC, FD, DX, XM). It detects load-use hazards and taken branches, and it runs the multicycle mult/div handshake FSM. From these it drives the per-latch stall lines and the bubble/flush selects. It sits beside the decode/execute stages and is the only source of latch enables (each latch enable = ~stall_*).

Parameters:
MD_TIMEOUT, 40, max WAIT cycles before forced completion (used only with MD_TIMEOUT_EN)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
fd_ir  in  32  instruction currently in FD latch (decode stage)
dx_ir  in  32  instruction currently in DX latch (execute stage)
branch_taken  in  1  X-stage branch/jump resolved taken this cycle
md_ready  in  1  mult/div unit result ready (level)
stall_pc  out  1  hold PC
stall_fd  out  1  hold FD latch
stall_dx  out  1  hold DX latch
stall_xm  out  1  hold XM latch
dx_bubble  out  1  select nop (32'b0) into DX input
fd_flush  out  1  select nop into FD input
md_start_mult  out  1  one-cycle mult start pulse
md_start_div  out  1  one-cycle div start pulse
md_busy  out  1  FSM in WAIT
md_result_valid  out  1  mult/div result may be captured into XM this cycle
md_timeout  out  1  one-cycle pulse on forced completion (0 when feature off)
stall_count  out  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Decode fields: opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2]. lw opcode=01000. R-type opcode=00000; mult aluop=00110; div aluop=00111.
- Sources of fd_ir:
  - R-type reads rs and rt.
  - sw (00111), bne (00010), blt (00110) read rd and rs.
  - jr (00100) reads rd.
  - Other I-types read rs.
  - Register 0 never causes a hazard.
- Load-use: dx_ir is lw, dx rd!=0, and dx rd matches any fd_ir source. Response (combinational, this cycle): stall_pc=stall_fd=1 and dx_bubble=1. DX and XM advance normally.
- Branch: branch_taken=1 gives fd_flush=1 and dx_bubble=1, with PC not stalled. Branch overrides load-use in the same cycle.
- Mult/div FSM states: IDLE, WAIT, DONE.
  - IDLE, dx_ir is mult/div: the matching md_start_* pulses for this cycle only. stall_pc=stall_fd=stall_dx=1. XM gets no stall, but stall_xm=0 and the X result is ignored downstream. Next state is WAIT with the counter cleared.
  - WAIT: md_busy=1; stall_pc/fd/dx=1; stall_xm=1; the cycle counter increments. If md_ready=1, next state is DONE.
  - DONE: md_result_valid=1 and all stalls are 0, so the mult/div leaves DX this cycle. Next state is always IDLE. DONE never re-issues a start.
  - A mult/div in DX in the cycle after DONE restarts from IDLE normally.
  - md_ready sampled in IDLE is ignored.
- Priority: WAIT stall > branch flush > load-use stall. branch_taken in WAIT is ignored, since no branch can be in X while a mult/div occupies DX.
- stall_count increments each cycle stall_pc=1 and saturates at all-ones.
- Reset (asserted low, asynchronous, including mid-WAIT):
  - state=IDLE; counters=0.
  - All registered outputs are 0.
  - Combinational outputs reflect IDLE with the current inputs.
- No output latency beyond what is stated: the hazard outputs are combinational from fd_ir/dx_ir/state; the start pulse occurs in the detection cycle.

Optional Feature:
MD_TIMEOUT_EN
- Defined: in WAIT, if the cycle counter reaches MD_TIMEOUT without md_ready, the FSM goes to DONE anyway. md_timeout pulses high for that DONE cycle together with md_result_valid.
- Undefined: there is no timeout counter compare. WAIT persists until md_ready, and md_timeout is tied to 0.

Test Plan:
- lw r5 in DX, add r1,r5,r2 in FD → one cycle stall_pc=stall_fd=1 and dx_bubble=1. The next cycle has no stall, and stall_count=1.
- lw r0 in DX, FD reads r0 → no stall; lw r5 in DX with sw r5 (rd=5) in FD → stall.
- mult in DX, md_ready rising 5 cycles after the start → md_start_mult for 1 cycle, md_busy for 5 cycles, stall_xm=1 during WAIT, then md_result_valid=1 for 1 cycle with stalls 0. stall_count=6.
- branch_taken with load-use hazard present in the same cycle → fd_flush=1, dx_bubble=1, stall_pc=0.
- reset pulled low mid-WAIT → outputs drop asynchronously and state is IDLE. After release with a div in DX, a fresh md_start_div pulse occurs.
- MD_TIMEOUT_EN, MD_TIMEOUT=40, md_ready held 0 → DONE after 40 WAIT cycles, with md_timeout=1 and md_result_valid=1 for one cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// pipeline_hazard_ctrl: load-use / taken-branch / mult-div stall and flush sequencer for the PC, FD, DX, XM latches.
// Optional feature macro: MD_TIMEOUT_EN forces mult/div completion after MD_TIMEOUT wait cycles.  Rev 1.0
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             stall_xm,
    output logic             dx_bubble,
    output logic             fd_flush,
    output logic             md_start_mult,
    output logic             md_start_div,
    output logic             md_busy,
    output logic             md_result_valid,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t state, next_state;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       uses_rs, uses_rt, uses_rd;
    logic       load_use, dx_is_mult, dx_is_div, md_hold, cnt_expired;

    assign fd_op    = fd_ir[31:27];
    assign fd_rd    = fd_ir[26:22];
    assign fd_rs    = fd_ir[21:17];
    assign fd_rt    = fd_ir[16:12];
    assign dx_op    = dx_ir[31:27];
    assign dx_rd    = dx_ir[26:22];
    assign dx_aluop = dx_ir[6:2];

    logic unused_bits;
    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0], (MD_TIMEOUT != 0)};

    // Source-register usage of the decode-stage instruction
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        uses_rd = 1'b0;
        case (fd_op)
            OP_RTYPE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                uses_rd = 1'b1;
                uses_rs = 1'b1;
            end
            OP_JR:   uses_rd = 1'b1;
            default: uses_rs = 1'b1;
        endcase
    end

    assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                      ((uses_rs && (fd_rs == dx_rd)) ||
                       (uses_rt && (fd_rt == dx_rd)) ||
                       (uses_rd && (fd_rd == dx_rd)));

    assign dx_is_mult = (dx_op == OP_RTYPE) && (dx_aluop == ALU_MULT);
    assign dx_is_div  = (dx_op == OP_RTYPE) && (dx_aluop == ALU_DIV);

`ifdef MD_TIMEOUT_EN
    localparam int TW = $clog2(MD_TIMEOUT + 1);
    logic [TW-1:0] md_cnt;
    logic          timed_out;

    assign cnt_expired = (md_cnt == TW'(MD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_cnt    <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == S_IDLE)
                md_cnt <= '0;
            else if (state == S_WAIT)
                md_cnt <= md_cnt + TW'(1);
            timed_out <= (state == S_WAIT) && !md_ready && cnt_expired;
        end
    end

    assign md_timeout = (state == S_DONE) && timed_out;
`else
    assign cnt_expired = 1'b0;
    assign md_timeout  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state      = state;
        stall_pc        = 1'b0;
        stall_fd        = 1'b0;
        stall_dx        = 1'b0;
        stall_xm        = 1'b0;
        dx_bubble       = 1'b0;
        fd_flush        = 1'b0;
        md_start_mult   = 1'b0;
        md_start_div    = 1'b0;
        md_busy         = 1'b0;
        md_result_valid = 1'b0;
        md_hold         = 1'b0;
        case (state)
            S_WAIT: begin
                md_hold  = 1'b1;
                md_busy  = 1'b1;
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                stall_dx = 1'b1;
                stall_xm = 1'b1;
                if (md_ready || cnt_expired)
                    next_state = S_DONE;
            end
            S_DONE: begin
                md_result_valid = 1'b1;
                next_state      = S_IDLE;
            end
            default: begin
                // XM still advances on issue; its X-stage result is discarded downstream
                if (dx_is_mult || dx_is_div) begin
                    md_hold       = 1'b1;
                    md_start_mult = dx_is_mult;
                    md_start_div  = dx_is_div;
                    stall_pc      = 1'b1;
                    stall_fd      = 1'b1;
                    stall_dx      = 1'b1;
                    next_state    = S_WAIT;
                end
            end
        endcase
        if (!md_hold) begin
            if (branch_taken) begin
                fd_flush  = 1'b1;
                dx_bubble = 1'b1;
            end else if (load_use) begin
                stall_pc  = 1'b1;
                stall_fd  = 1'b1;
                dx_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall_pc && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// tb_pipeline_hazard_ctrl: directed vectors checked every cycle against a behavioural model, plus literal pins.
module tb_pipeline_hazard_ctrl;
    localparam int MDT   = 40;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [31:0] NOP = 32'h0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [31:0] fd_ir = '0, dx_ir = '0;
    logic branch_taken = 1'b0, md_ready = 1'b0;
    logic stall_pc, stall_fd, stall_dx, stall_xm, dx_bubble, fd_flush;
    logic md_start_mult, md_start_div, md_busy, md_result_valid, md_timeout;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx), .stall_xm(stall_xm),
        .dx_bubble(dx_bubble), .fd_flush(fd_flush),
        .md_start_mult(md_start_mult), .md_start_div(md_start_div),
        .md_busy(md_busy), .md_result_valid(md_result_valid), .md_timeout(md_timeout),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    logic [10:0] dut_outs;
    assign dut_outs = {stall_pc, stall_fd, stall_dx, stall_xm, dx_bubble, fd_flush,
                       md_start_mult, md_start_div, md_busy, md_result_valid, md_timeout};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Instruction builders
    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input int alu);
        return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b0, 5'(alu), 2'b0};
    endfunction
    function automatic logic [31:0] itype(input int op, input int rd, input int rs);
        return {5'(op), 5'(rd), 5'(rs), 17'h00044};
    endfunction

    // ---------------- behavioural model ----------------
    bit m_wait = 0, m_done = 0, m_timed_out = 0;
    int m_waited = 0;
    int m_count  = 0;

    function automatic bit reads(input logic [31:0] ir, input logic [4:0] r);
        logic [4:0] op;
        op = ir[31:27];
        if (r == 5'd0) return 1'b0;
        if (op == 5'b00000) return (ir[21:17] == r) || (ir[16:12] == r);
        if (op inside {5'b00111, 5'b00010, 5'b00110}) return (ir[26:22] == r) || (ir[21:17] == r);
        if (op == 5'b00100) return ir[26:22] == r;
        return ir[21:17] == r;
    endfunction

    function automatic logic [10:0] model_out();
        bit sp, sf, sd, sx, bub, fl, sm, sdv, bz, rv, to, mul, dv;
        {sp, sf, sd, sx, bub, fl, sm, sdv, bz, rv, to} = '0;
        mul = (dx_ir[31:27] == 5'd0) && (dx_ir[6:2] == 5'd6);
        dv  = (dx_ir[31:27] == 5'd0) && (dx_ir[6:2] == 5'd7);
        if (m_wait) begin
            {sp, sf, sd, sx, bz} = 5'b11111;
        end else if (!m_done && (mul || dv)) begin
            sm = mul; sdv = dv; {sp, sf, sd} = 3'b111;
        end else begin
            if (m_done) begin rv = 1; to = m_timed_out; end
            if (branch_taken) begin
                fl = 1; bub = 1;
            end else if (dx_ir[31:27] == 5'b01000 && reads(fd_ir, dx_ir[26:22])) begin
                sp = 1; sf = 1; bub = 1;
            end
        end
        return {sp, sf, sd, sx, bub, fl, sm, sdv, bz, rv, to};
    endfunction

    logic [10:0] exp_outs;
    always_comb exp_outs = model_out();

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_wait <= 0; m_done <= 0; m_timed_out <= 0; m_waited <= 0; m_count <= 0;
        end else begin
            m_count <= (m_count + int'(exp_outs[10]) > CMAX) ? CMAX : m_count + int'(exp_outs[10]);
            if (m_wait) begin
                m_waited <= m_waited + 1;
                if (md_ready) begin
                    m_wait <= 0; m_done <= 1; m_timed_out <= 0;
                end
`ifdef MD_TIMEOUT_EN
                else if (m_waited + 1 == MDT) begin
                    m_wait <= 0; m_done <= 1; m_timed_out <= 1;
                end
`endif
            end else if (m_done) begin
                m_done <= 0; m_timed_out <= 0;
            end else if (exp_outs[4] || exp_outs[3]) begin
                m_wait <= 1; m_waited <= 0;
            end
        end
    end

    always @(negedge clock) begin
        check("outputs", 32'(dut_outs), 32'(exp_outs));
        check("stall_count", 32'(stall_count), 32'(m_count));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] f, input logic [31:0] d, input logic bt, input logic rdy);
        @(posedge clock); #1;
        fd_ir = f; dx_ir = d; branch_taken = bt; md_ready = rdy;
        @(negedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 0; fd_ir = NOP; dx_ir = NOP; branch_taken = 0; md_ready = 0;
        #3 reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] lw5, mult, dvi;
    initial begin
        lw5  = itype(8, 5, 3);
        mult = rtype(4, 1, 2, 6);
        dvi  = rtype(6, 1, 2, 7);
        repeat (2) @(posedge clock);
        #1 reset = 1;

        drive(NOP, NOP, 0, 0);
        check("reset_outs", 32'(dut_outs), 32'h0);
        check("reset_count", 32'(stall_count), 32'h0);

        // load-use on R-type rs
        drive(rtype(1, 5, 2, 0), lw5, 0, 0);
        check("lu_outs", 32'(dut_outs), 32'(11'b11001000000));
        drive(rtype(1, 5, 2, 0), NOP, 0, 0);
        check("lu_release", 32'(dut_outs), 32'h0);
        check("lu_count", 32'(stall_count), 32'd1);

        // r0 never hazards; sw/jr/rt sources; non-matching I-type
        drive(rtype(1, 0, 2, 0), itype(8, 0, 3), 0, 0);
        check("r0_nostall", 32'(stall_pc), 32'd0);
        drive(itype(7, 5, 9), lw5, 0, 0);
        check("sw_stall", 32'(stall_pc), 32'd1);
        drive(itype(4, 5, 0), lw5, 0, 0);
        drive(rtype(1, 2, 5, 0), lw5, 0, 0);
        drive(itype(5, 5, 2), lw5, 0, 0);
        check("addi_rd_nostall", 32'(stall_pc), 32'd0);
        drive(itype(2, 9, 5), lw5, 0, 0);

        // branch overrides load-use
        drive(rtype(1, 5, 2, 0), lw5, 1, 0);
        check("br_over_lu", 32'(dut_outs), 32'(11'b00001100000));

        // mult with md_ready in the 5th wait cycle
        do_reset();
        drive(NOP, mult, 0, 0);
        check("mult_issue", 32'(dut_outs), 32'(11'b11100010000));
        for (int i = 0; i < 4; i++) drive(NOP, mult, 0, 0);
        check("mult_wait", 32'(dut_outs), 32'(11'b11110000100));
        drive(NOP, mult, 0, 1);
        drive(NOP, mult, 0, 0);
        check("mult_done", 32'(dut_outs), 32'(11'b00000000010));
        drive(NOP, NOP, 0, 0);
        check("mult_count", 32'(stall_count), 32'd6);

        // back-to-back mult/div after DONE, and ready ignored in IDLE
        drive(NOP, NOP, 0, 1);
        drive(NOP, dvi, 0, 0);
        drive(NOP, dvi, 0, 1);
        drive(NOP, dvi, 0, 0);
        drive(NOP, mult, 0, 0);
        check("restart_after_done", 32'(md_start_mult), 32'd1);
        drive(NOP, mult, 1, 1);
        drive(NOP, mult, 0, 0);
        drive(NOP, NOP, 0, 0);

        // asynchronous reset mid-WAIT
        drive(NOP, dvi, 0, 0);
        drive(NOP, dvi, 0, 0);
        drive(NOP, dvi, 0, 0);
        reset = 0;
        #1;
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_xm", 32'(stall_xm), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        fd_ir = NOP; dx_ir = NOP;
        #1 reset = 1;
        drive(NOP, dvi, 0, 0);
        check("div_restart", 32'(md_start_div), 32'd1);
        drive(NOP, dvi, 0, 1);
        drive(NOP, dvi, 0, 0);
        drive(NOP, NOP, 0, 0);

        // md_ready held low for MD_TIMEOUT wait cycles
        do_reset();
        drive(NOP, mult, 0, 0);
        for (int i = 0; i < MDT; i++) drive(NOP, mult, 0, 0);
`ifdef MD_TIMEOUT_EN
        check("timeout_done", 32'(dut_outs), 32'(11'b00000000011));
`else
        check("no_timeout_busy", 32'(md_busy), 32'd1);
        check("no_timeout_flag", 32'(md_timeout), 32'd0);
        drive(NOP, mult, 0, 1);
        drive(NOP, mult, 0, 0);
        check("late_done", 32'(md_result_valid), 32'd1);
`endif
        check("count_saturated", 32'(stall_count), 32'(CMAX));
        drive(NOP, NOP, 0, 0);

        @(posedge clock); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
